// File: rtl/pc_unit_ras.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit_ras
// Purpose  : Program-counter unit for the multi-cycle MIPS datapath. Holds the
//            PC and selects the next PC from sequential, branch, jump, jr,
//            jal (call) and return sources. Includes a circular return-address
//            stack, beq/bne branch modes, stall, an exception redirect with EPC
//            capture, and status flags.
// Ports    : clk           rising-edge clock
//            rst           asynchronous active-low reset
//            stall         freeze PC, RAS, EPC and flags
//            exc           exception request (overrides stall)
//            PCWrite       unconditional PC update enable
//            PCWriteCond   conditional branch enable
//            BranchNe      0 = branch on zero, 1 = branch on not-zero
//            zero          ALU zero flag
//            PCSource[2:0] next-PC source select
//            result        ALU result (PC+4 in fetch)
//            ALUOut        registered branch target
//            IR_low26      jump index field
//            reg_target    rs value for jr / empty-stack return
//            PCvalue       current PC
//            epc           PC captured at the last exception
//            ras_top       top-of-stack entry, 0 when empty
//            ras_count     number of valid stack entries
//            ras_overflow  sticky: push while full
//            ras_underflow sticky: pop while empty
//            misaligned    PCvalue[1:0] != 0
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit_ras #(
  parameter int              WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 'h0000_0000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 'h0000_0180,
  parameter int              RAS_DEPTH    = 4,
  parameter int              RAS_PTR_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 exc,
  input  logic                 PCWrite,
  input  logic                 PCWriteCond,
  input  logic                 BranchNe,
  input  logic                 zero,
  input  logic [2:0]           PCSource,
  input  logic [WIDTH-1:0]     result,
  input  logic [WIDTH-1:0]     ALUOut,
  input  logic [25:0]          IR_low26,
  input  logic [WIDTH-1:0]     reg_target,
  output logic [WIDTH-1:0]     PCvalue,
  output logic [WIDTH-1:0]     epc,
  output logic [WIDTH-1:0]     ras_top,
  output logic [RAS_PTR_W:0]   ras_count,
  output logic                 ras_overflow,
  output logic                 ras_underflow,
  output logic                 misaligned
);

  localparam logic [2:0] C_SRC_SEQ = 3'b000;
  localparam logic [2:0] C_SRC_ALU = 3'b001;
  localparam logic [2:0] C_SRC_J   = 3'b010;
  localparam logic [2:0] C_SRC_JR  = 3'b011;
  localparam logic [2:0] C_SRC_JAL = 3'b100;
  localparam logic [2:0] C_SRC_RET = 3'b101;

  localparam logic [RAS_PTR_W:0]   C_DEPTH   = (RAS_PTR_W+1)'(RAS_DEPTH);
  localparam logic [RAS_PTR_W:0]   C_CNT_ONE = 1;
  localparam logic [RAS_PTR_W-1:0] C_PTR_ONE = 1;

  logic [WIDTH-1:0]     pc_q, pc_d;
  logic [WIDTH-1:0]     epc_q, epc_d;
  logic [RAS_PTR_W-1:0] ptr_q, ptr_d;
  logic [RAS_PTR_W:0]   cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 push;
  logic                 pop;
  logic                 branch_taken;
  logic [WIDTH-1:0]     jump_tgt;
  logic [WIDTH-1:0]     top_entry;

  // Entry contents need no reset: ras_top is masked to 0 while the stack is empty.
  logic [WIDTH-1:0]     ras_mem [RAS_DEPTH];

  // The region bits above bit 27 only exist when WIDTH exceeds 28.
  if (WIDTH > 28) begin : g_jt_wide
    assign jump_tgt = {pc_q[WIDTH-1:28], IR_low26, 2'b00};
  end else begin : g_jt_narrow
    assign jump_tgt = {IR_low26, 2'b00};
  end

  assign branch_taken = PCWriteCond & (zero ^ BranchNe);
  assign top_entry    = ras_mem[ptr_q - C_PTR_ONE];

  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    pop   = 1'b0;

    if (exc) begin
      pc_d  = EXC_VECTOR;
      epc_d = pc_q;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (branch_taken) begin
      pc_d = ALUOut;
    end else if (PCWrite) begin
      case (PCSource)
        C_SRC_SEQ: pc_d = result;
        C_SRC_ALU: pc_d = ALUOut;
        C_SRC_J:   pc_d = jump_tgt;
        C_SRC_JR:  pc_d = reg_target;
        C_SRC_JAL: begin
          pc_d = jump_tgt;
          push = 1'b1;
        end
        C_SRC_RET: begin
          if (cnt_q != '0) begin
            pc_d = top_entry;
            pop  = 1'b1;
          end else begin
            // Empty stack falls back to the register target.
            pc_d  = reg_target;
            unf_d = 1'b1;
          end
        end
        default: pc_d = pc_q;
      endcase
    end

    if (push) begin
      // Pointer wraps, so a push while full overwrites the oldest entry.
      ptr_d = ptr_q + C_PTR_ONE;
      if (cnt_q == C_DEPTH) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + C_CNT_ONE;
      end
    end else if (pop) begin
      ptr_d = ptr_q - C_PTR_ONE;
      cnt_d = cnt_q - C_CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      ras_mem[ptr_q] <= result;
    end
  end

  assign PCvalue       = pc_q;
  assign epc           = epc_q;
  assign ras_top       = (cnt_q != '0) ? top_entry : '0;
  assign ras_count     = cnt_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
  assign misaligned    = |pc_q[1:0];

endmodule
`default_nettype wire

// File: tb/tb_pc_unit_ras.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit_ras
// Purpose  : Self-checking bench for pc_unit_ras. A queue-based reference
//            model tracks PC, EPC and the return-address stack; a compare
//            process checks every DUT output against it on each falling edge,
//            and directed sequences pin the model with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit_ras;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        exc = 1'b0;
  logic        PCWrite = 1'b0;
  logic        PCWriteCond = 1'b0;
  logic        BranchNe = 1'b0;
  logic        zero = 1'b0;
  logic [2:0]  PCSource = 3'b000;
  logic [31:0] result = 32'h0;
  logic [31:0] ALUOut = 32'h0;
  logic [25:0] IR_low26 = 26'h0;
  logic [31:0] reg_target = 32'h0;
  logic [31:0] PCvalue;
  logic [31:0] epc;
  logic [31:0] ras_top;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;
  logic        misaligned;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  pc_unit_ras dut (
    .clk(clk), .rst(rst), .stall(stall), .exc(exc),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
    .zero(zero), .PCSource(PCSource), .result(result), .ALUOut(ALUOut),
    .IR_low26(IR_low26), .reg_target(reg_target), .PCvalue(PCvalue),
    .epc(epc), .ras_top(ras_top), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  // Reference model: the stack is a queue, oldest at the front.
  logic [31:0] m_pc  = 32'h0;
  logic [31:0] m_epc = 32'h0;
  logic [31:0] m_q[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;

  always @(posedge clk or negedge rst) begin
    logic [31:0] jt;
    if (!rst) begin
      m_pc  = 32'h0;
      m_epc = 32'h0;
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      jt = {m_pc[31:28], IR_low26, 2'b00};
      if (exc) begin
        m_epc = m_pc;
        m_pc  = 32'h180;
      end else if (stall) begin
        m_pc = m_pc;
      end else if (PCWriteCond && (zero != BranchNe)) begin
        m_pc = ALUOut;
      end else if (PCWrite) begin
        case (PCSource)
          3'd0: m_pc = result;
          3'd1: m_pc = ALUOut;
          3'd2: m_pc = jt;
          3'd3: m_pc = reg_target;
          3'd4: begin
            m_q.push_back(result);
            if (m_q.size() > 4) begin
              void'(m_q.pop_front());
              m_ovf = 1'b1;
            end
            m_pc = jt;
          end
          3'd5: begin
            if (m_q.size() > 0) m_pc = m_q.pop_back();
            else begin
              m_pc  = reg_target;
              m_unf = 1'b1;
            end
          end
          default: m_pc = m_pc;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc",        PCvalue, m_pc);
      chk("epc",       epc, m_epc);
      chk("ras_top",   ras_top, (m_q.size() > 0) ? m_q[$] : 32'h0);
      chk("ras_count", {29'h0, ras_count}, m_q.size());
      chk("ras_ovf",   {31'h0, ras_overflow}, {31'h0, m_ovf});
      chk("ras_unf",   {31'h0, ras_underflow}, {31'h0, m_unf});
      chk("misalign",  {31'h0, misaligned}, {31'h0, |m_pc[1:0]});
    end
  end

  task automatic idle();
    stall = 1'b0; exc = 1'b0; PCWrite = 1'b0; PCWriteCond = 1'b0;
    BranchNe = 1'b0; zero = 1'b0; PCSource = 3'b000;
  endtask

  // Applies the current inputs at the next rising edge; returns just after it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic op(input logic [2:0] src, input logic [31:0] res, input logic [31:0] rt);
    idle();
    PCWrite = 1'b1; PCSource = src; result = res; reg_target = rt;
    tick();
  endtask

  initial begin
    logic [31:0] pc_before;

    // Reset asserted mid-cycle must clear the PC without a clock edge.
    op(3'd0, 32'h1234_5678, 32'h0);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_async_pc", PCvalue, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_count", {29'h0, ras_count}, 32'h0);
    chk("rst_top", ras_top, 32'h0);
    PCWrite = 1'b1; PCSource = 3'd0; result = 32'h4;
    tick();
    chk("rst_hold_pc", PCvalue, 32'h0);
    rst = 1'b1;
    cmp_en = 1'b1;
    tick();
    chk("first_seq", PCvalue, 32'h4);

    // Branch modes.
    idle(); PCWriteCond = 1'b1; zero = 1'b1; BranchNe = 1'b0; ALUOut = 32'h40;
    tick();
    chk("beq_taken", PCvalue, 32'h40);
    BranchNe = 1'b1; ALUOut = 32'h60;
    tick();
    chk("bne_not_taken", PCvalue, 32'h40);
    BranchNe = 1'b0; ALUOut = 32'h80; PCWrite = 1'b1; PCSource = 3'd0; result = 32'h99;
    tick();
    chk("branch_over_pcwrite", PCvalue, 32'h80);

    // Jump keeps the region bits.
    op(3'd0, 32'hA000_0010, 32'h0);
    IR_low26 = 26'h123;
    op(3'd2, 32'h0, 32'h0);
    chk("jump", PCvalue, 32'hA000_048C);

    // Call / return with underflow.
    op(3'd4, 32'h104, 32'h0);
    op(3'd4, 32'h208, 32'h0);
    chk("jal_count", {29'h0, ras_count}, 32'd2);
    op(3'd5, 32'h0, 32'h0);
    chk("ret1", PCvalue, 32'h208);
    chk("ret1_count", {29'h0, ras_count}, 32'd1);
    op(3'd5, 32'h0, 32'h0);
    chk("ret2", PCvalue, 32'h104);
    chk("ret2_count", {29'h0, ras_count}, 32'd0);
    op(3'd5, 32'h0, 32'h300);
    chk("ret_empty", PCvalue, 32'h300);
    chk("underflow", {31'h0, ras_underflow}, 32'd1);

    // Overflow overwrites the oldest entry.
    for (int i = 1; i <= 5; i++) op(3'd4, 32'h10 * i, 32'h0);
    chk("ovf_count", {29'h0, ras_count}, 32'd4);
    chk("ovf_flag", {31'h0, ras_overflow}, 32'd1);
    chk("ovf_top", ras_top, 32'h50);
    for (int i = 5; i >= 2; i--) begin
      op(3'd5, 32'h0, 32'hDEAD_0000);
      chk("ovf_ret", PCvalue, 32'h10 * i);
    end

    // Stall, exception, reserved source, misaligned flag.
    pc_before = PCvalue;
    idle(); stall = 1'b1; PCWrite = 1'b1; PCSource = 3'd4; result = 32'h777;
    tick();
    chk("stall_pc", PCvalue, pc_before);
    chk("stall_count", {29'h0, ras_count}, 32'd0);
    op(3'd0, 32'h88, 32'h0);
    idle(); exc = 1'b1; stall = 1'b1;
    tick();
    chk("exc_pc", PCvalue, 32'h180);
    chk("exc_epc", epc, 32'h88);
    op(3'd7, 32'h44, 32'h0);
    chk("reserved_hold", PCvalue, 32'h180);
    op(3'd0, 32'h6, 32'h0);
    chk("misaligned", {31'h0, misaligned}, 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      exc         = ($urandom_range(0, 40) == 0);
      stall       = ($urandom_range(0, 12) == 0);
      PCWrite     = ($urandom_range(0, 3) != 0);
      PCWriteCond = ($urandom_range(0, 5) == 0);
      BranchNe    = 1'($urandom_range(0, 1));
      zero        = 1'($urandom_range(0, 1));
      PCSource    = 3'($urandom_range(0, 7));
      result      = $urandom();
      ALUOut      = $urandom();
      IR_low26    = 26'($urandom());
      reg_target  = $urandom();
      tick();
    end

    idle();
    tick();
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
